// File: rtl/pwm_multi_generator.sv
`default_nettype none
// ============================================================================
// pwm_multi_generator : multi-channel PWM, shared period counter, double-
// buffered duty/period/mode. Define PWM_CENTER_ALIGN_EN for center alignment.
// Revision: 1.0
// ============================================================================
module pwm_multi_generator #(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [1:0]          sel,
    input  logic                wr_en,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_end
);

    localparam logic [WIDTH-1:0] c_zero       = '0;
    localparam logic [WIDTH-1:0] c_one        = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_ones       = '1;
    localparam logic [1:0]       c_sel_duty   = 2'b00;
    localparam logic [1:0]       c_sel_period = 2'b01;

    logic [WIDTH-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_period_sh;
    logic [WIDTH-1:0]    r_period_act;
    logic [CHANNELS-1:0] r_pwm_out;
    logic                r_period_end;
    logic [CHANNELS-1:0] w_cmp;
    logic                w_boundary;

    // Active registers load on the edge that ends a boundary cycle; a write on
    // that same edge only reaches the shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_sh  <= c_ones;
            r_period_act <= c_ones;
        end else begin
            if (w_boundary) begin
                r_period_act <= r_period_sh;
            end
            if (wr_en && (sel == c_sel_period)) begin
                r_period_sh <= wr_data;
            end
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    localparam logic [1:0] c_sel_mode = 2'b10;

    logic r_mode_sh;
    logic r_mode_act;
    logic r_dir_down;
    logic w_edge_bnd;
    logic w_center_bnd;

    // Center boundary is the cycle whose successor count is 0.
    always_comb begin
        w_edge_bnd   = (r_cnt == r_period_act);
        w_center_bnd = (r_dir_down && (r_cnt == c_one)) ||
                       ((r_period_act <= c_one) && (r_cnt == r_period_act));
        w_boundary   = r_mode_act ? w_center_bnd : w_edge_bnd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_sh  <= 1'b0;
            r_mode_act <= 1'b0;
            r_dir_down <= 1'b0;
            r_cnt      <= c_zero;
        end else begin
            if (wr_en && (sel == c_sel_mode)) begin
                r_mode_sh <= wr_data[0];
            end
            if (w_boundary) begin
                r_mode_act <= r_mode_sh;
                r_dir_down <= 1'b0;
                r_cnt      <= c_zero;
            end else if (!r_mode_act) begin
                r_cnt <= r_cnt + c_one;
            end else if (r_dir_down) begin
                r_cnt <= r_cnt - c_one;
            end else if (r_cnt == r_period_act) begin
                r_dir_down <= 1'b1;
                r_cnt      <= r_cnt - c_one;
            end else begin
                r_cnt <= r_cnt + c_one;
            end
        end
    end
`else
    assign w_boundary = (r_cnt == r_period_act);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= c_zero;
        end else if (w_boundary) begin
            r_cnt <= c_zero;
        end else begin
            r_cnt <= r_cnt + c_one;
        end
    end
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [CH_W-1:0] c_idx = CH_W'(i);

        logic [WIDTH-1:0] r_duty_sh;
        logic [WIDTH-1:0] r_duty_act;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_duty_sh  <= c_zero;
                r_duty_act <= c_zero;
            end else begin
                if (w_boundary) begin
                    r_duty_act <= r_duty_sh;
                end
                if (wr_en && (sel == c_sel_duty) && (wr_ch == c_idx)) begin
                    r_duty_sh <= wr_data;
                end
            end
        end

        assign w_cmp[i] = (r_cnt < r_duty_act);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_out    <= '0;
            r_period_end <= 1'b0;
        end else begin
            r_pwm_out    <= w_cmp;
            r_period_end <= w_boundary;
        end
    end

    assign pwm_out    = r_pwm_out;
    assign period_end = r_period_end;

endmodule
`default_nettype wire
